// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command controller: FSM encoding, ASCII
// constants and character helpers.
package uart_cmd_pkg;

   typedef enum logic [2:0] {IDLE, HDR, CH, EXEC, TX0, W0, TX1, W1} state_t;

   localparam logic [7:0] C_M   = 8'h4D;
   localparam logic [7:0] C_K   = 8'h4B;
   localparam logic [7:0] C_E   = 8'h45;
   localparam logic [7:0] C_S   = 8'h53;
   localparam logic [7:0] C_C   = 8'h43;
   localparam logic [7:0] C_V   = 8'h56;
   localparam logic [7:0] C_QRY = 8'h3F;
   localparam logic [7:0] C_0   = 8'h30;
   localparam logic [7:0] C_1   = 8'h31;

   function automatic logic ch_valid(input logic [7:0] b, input int ch_num);
      return (b >= C_0) && (int'(b) < int'(C_0) + ch_num);
   endfunction

   // 'A' is 8'h41 = 8'h37 + 10
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
   endfunction

endpackage

// File: rtl/uart_tx_seq.sv
// Two-byte reply sequencer: issues tx_start per byte only while the
// transmitter is idle, and strobes done once the second byte has completed.
module uart_tx_seq
   import uart_cmd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       go,
   input  logic [7:0] b0,
   input  logic [7:0] b1,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       done
);

   state_t     state, state_nx;
   logic [7:0] r0, r1;
   logic       skip, skip_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         r0    <= '0;
         r1    <= '0;
         skip  <= 1'b0;
      end else begin
         state <= state_nx;
         skip  <= skip_nx;
         if (go && state == IDLE) begin
            r0 <= b0;
            r1 <= b1;
         end
      end
   end

   // busy only rises the cycle after tx_start, so the first wait cycle is ignored
   always_comb begin
      state_nx = state;
      skip_nx  = 1'b0;
      tx_start = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: if (go) state_nx = TX0;
         TX0: if (!tx_busy) begin
            tx_start = 1'b1;
            skip_nx  = 1'b1;
            state_nx = W0;
         end
         W0: if (!skip && !tx_busy) state_nx = TX1;
         TX1: if (!tx_busy) begin
            tx_start = 1'b1;
            skip_nx  = 1'b1;
            state_nx = W1;
         end
         W1: if (!skip && !tx_busy) begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign tx_data = (state == TX1 || state == W1) ? r1 : r0;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses 'M' <ch> <val> commands into the channel enable register and replies
// via uart_tx_seq. UART_CMD_QUERY_EN adds the 'M' '?' '?' status query.
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int         CH_NUM      = 4,
   parameter int         TIMEOUT_CYC = 1000000,
   parameter logic [7:0] HDR_CHAR    = C_M
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_done,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic [CH_NUM-1:0] ch_en,
   output logic [CH_NUM-1:0] ch_pulse,
   output logic              cmd_err
);

   localparam int            CW      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT_CYC - 1);

   state_t            state, state_nx;
   logic [3:0]        idx, idx_nx;
   logic              val, val_nx;
   logic [CW-1:0]     tmo;
   logic              tmo_hit;
   logic              go, done;
   logic [7:0]        rep0, rep1;
   logic [CH_NUM-1:0] ch_en_d, sel;

`ifdef UART_CMD_QUERY_EN
   logic       qry, qry_nx;
   logic [3:0] en_lo;

   always_comb begin
      en_lo = '0;
      for (int i = 0; i < CH_NUM && i < 4; i++) en_lo[i] = ch_en[i];
   end

   always_ff @(posedge clk) begin
      if (rst) qry <= 1'b0;
      else     qry <= qry_nx;
   end
`endif

   assign tmo_hit  = (tmo == TMO_MAX);
   assign sel      = CH_NUM'(1) << idx;
   assign ch_pulse = ch_en & ~ch_en_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= '0;
         val     <= 1'b0;
         tmo     <= '0;
         ch_en   <= '0;
         ch_en_d <= '0;
      end else begin
         state   <= state_nx;
         idx     <= idx_nx;
         val     <= val_nx;
         ch_en_d <= ch_en;
         if (state == EXEC) ch_en <= val ? (ch_en | sel) : (ch_en & ~sel);
         if (rx_done || !(state == HDR || state == CH)) tmo <= '0;
         else if (!tmo_hit)                              tmo <= tmo + CW'(1);
      end
   end

   // error replies default to 'E','C'; a received byte always beats a timeout
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      val_nx   = val;
      go       = 1'b0;
      rep0     = C_E;
      rep1     = C_C;
      cmd_err  = 1'b0;
`ifdef UART_CMD_QUERY_EN
      qry_nx   = qry;
`endif
      case (state)
         IDLE: if (rx_done && rx_data == HDR_CHAR) begin
            state_nx = HDR;
`ifdef UART_CMD_QUERY_EN
            qry_nx   = 1'b0;
`endif
         end
         HDR: if (rx_done) begin
            if (rx_data == HDR_CHAR) state_nx = HDR;
`ifdef UART_CMD_QUERY_EN
            else if (rx_data == C_QRY) begin
               qry_nx   = 1'b1;
               state_nx = CH;
            end
`endif
            else if (ch_valid(rx_data, CH_NUM)) begin
               idx_nx   = rx_data[3:0];
               state_nx = CH;
            end else begin
               go       = 1'b1;
               cmd_err  = 1'b1;
               state_nx = TX0;
            end
         end else if (tmo_hit) begin
            cmd_err  = 1'b1;
            state_nx = IDLE;
         end
         CH: if (rx_done) begin
`ifdef UART_CMD_QUERY_EN
            if (qry) begin
               go       = 1'b1;
               state_nx = TX0;
               if (rx_data == C_QRY) begin
                  rep0 = C_S;
                  rep1 = hex_ascii(en_lo);
               end else begin
                  rep1    = C_V;
                  cmd_err = 1'b1;
               end
            end else
`endif
            if (rx_data == C_0 || rx_data == C_1) begin
               val_nx   = rx_data[0];
               state_nx = EXEC;
            end else if (rx_data == HDR_CHAR) begin
               state_nx = HDR;
            end else begin
               go       = 1'b1;
               rep1     = C_V;
               cmd_err  = 1'b1;
               state_nx = TX0;
            end
         end else if (tmo_hit) begin
            cmd_err  = 1'b1;
            state_nx = IDLE;
         end
         EXEC: begin
            go       = 1'b1;
            rep0     = C_K;
            rep1     = {4'h3, idx};
            state_nx = TX0;
         end
         // TX0 here stands for the whole reply handled by the sequencer
         TX0: if (done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   uart_tx_seq u_seq (
      .clk      (clk),
      .rst      (rst),
      .go       (go),
      .b0       (rep0),
      .b1       (rep1),
      .tx_busy  (tx_busy),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .done     (done)
   );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: byte-level command model, 10-cycle busy transmitter
// model, and checks on replies, enables, pulses and error strobes.
module tb_uart_cmd_ctrl;

   localparam int         CH_NUM = 4;
   localparam int         TMO    = 100;
   localparam logic [7:0] HDR    = 8'h4D;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [7:0]        rx_data = '0;
   logic              rx_done = 1'b0;
   logic [7:0]        tx_data;
   logic              tx_start, tx_busy, cmd_err;
   logic [CH_NUM-1:0] ch_en, ch_pulse;

   uart_cmd_ctrl #(.CH_NUM(CH_NUM), .TIMEOUT_CYC(TMO), .HDR_CHAR(HDR)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .ch_en(ch_en), .ch_pulse(ch_pulse), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   // transmitter model and event monitors (not affected by rst)
   int         bcnt = 0, viol = 0, errs = 0;
   int         pcnt [CH_NUM];
   logic [7:0] txq [$];
   assign tx_busy = (bcnt != 0);

   always @(posedge clk) begin
      if (tx_start) begin
         if (tx_busy) viol <= viol + 1;
         txq.push_back(tx_data);
         bcnt <= 10;
      end else if (bcnt != 0) bcnt <= bcnt - 1;
      if (cmd_err) errs <= errs + 1;
      for (int i = 0; i < CH_NUM; i++) if (ch_pulse[i]) pcnt[i] <= pcnt[i] + 1;
   end

   // reference model: ph 0 idle, 1 header seen, 2 channel seen, 3 reply pending
   int                nvec = 0, nfail = 0;
   int                ph = 0, mch = 0, eerr = 0;
   bit                mq = 0;
   int                epul [CH_NUM];
   logic [CH_NUM-1:0] men = '0;
   logic [7:0]        expq [$];
   string             hx = "0123456789ABCDEF";

   function automatic void reply(logic [7:0] a, logic [7:0] b, int e);
      expq.push_back(a);
      expq.push_back(b);
      eerr += e;
      ph = 3;
   endfunction

   function automatic void mbyte(logic [7:0] b);
      case (ph)
         0: if (b == HDR) ph = 1;
         1: begin
            if (b == HDR) ph = 1;
            else if (b >= 8'h30 && int'(b) < 8'h30 + CH_NUM) begin
               mch = int'(b) - 8'h30; mq = 0; ph = 2;
            end
`ifdef UART_CMD_QUERY_EN
            else if (b == "?") begin mq = 1; ph = 2; end
`endif
            else reply("E", "C", 1);
         end
         2: begin
            if (mq) begin
               if (b == "?") reply("S", hx[int'(men)], 0);
               else reply("E", "V", 1);
            end else if (b == "0" || b == "1") begin
               if (b == "1" && !men[mch]) epul[mch]++;
               men[mch] = b[0];
               reply("K", 8'(8'h30 + mch), 0);
            end else if (b == HDR) ph = 1;
            else reply("E", "V", 1);
         end
         default: ;
      endcase
   endfunction

   function automatic string q2s(logic [7:0] q [$]);
      string s = "";
      foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
      return s;
   endfunction

   task automatic send_byte(logic [7:0] b, int gap);
      @(negedge clk); rx_data = b; rx_done = 1'b1; mbyte(b);
      @(negedge clk); rx_done = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while ((txq.size() < expq.size() || tx_busy) && n < 400) begin
         @(negedge clk); n++;
      end
      repeat (6) @(negedge clk);
      if (ph == 3) ph = 0;
   endtask

   task automatic send_cmd(logic [7:0] a, logic [7:0] b, logic [7:0] c);
      send_byte(a, $urandom_range(3, 0));
      send_byte(b, $urandom_range(3, 0));
      send_byte(c, $urandom_range(3, 0));
      if (ph == 1 || ph == 2) begin
         repeat (TMO + 10) @(negedge clk);
         eerr++; ph = 0;
      end
      drain();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      nvec++;
      if ({ch_en, ch_pulse, tx_start, tx_data, cmd_err} !== '0) begin
         nfail++;
         $display("FAIL reset_outputs got en=%b pul=%b st=%b d=%h err=%b want all 0",
                  ch_en, ch_pulse, tx_start, tx_data, cmd_err);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_latency();
      txq.delete(); expq.delete();
      send_byte("M", 1);
      send_byte("2", 2);
      @(negedge clk); rx_data = "1"; rx_done = 1'b1; mbyte("1");
      @(negedge clk); rx_done = 1'b0;
      nvec++;
      if (ch_en !== 4'b0000) begin
         nfail++; $display("FAIL lat_en_early got %b want 0000", ch_en);
      end
      @(negedge clk);
      nvec++;
      if ({ch_en, ch_pulse, tx_start, tx_data} !== {4'b0100, 4'b0100, 1'b1, 8'h4B}) begin
         nfail++;
         $display("FAIL lat_t2 got en=%b pul=%b st=%b d=%h want 0100 0100 1 4b",
                  ch_en, ch_pulse, tx_start, tx_data);
      end
      drain();
      nvec++;
      if (q2s(txq) != q2s(expq)) begin
         nfail++; $display("FAIL lat_reply got %s want %s", q2s(txq), q2s(expq));
      end
      nvec++;
      if (pcnt[2] !== 1 || viol !== 0) begin
         nfail++; $display("FAIL lat_pulse_busy got pulses=%0d viol=%0d want 1 0", pcnt[2], viol);
      end
   endtask

   task automatic test_repeat();
      txq.delete(); expq.delete();
      send_cmd("M", "2", "1");
      send_cmd("M", "2", "0");
      nvec++;
      if (q2s(txq) != q2s(expq) || expq.size() != 4) begin
         nfail++; $display("FAIL rep_reply got %s want %s", q2s(txq), q2s(expq));
      end
      nvec++;
      if (pcnt[2] !== epul[2] || ch_en !== men || men !== 4'b0000) begin
         nfail++;
         $display("FAIL rep_state got pulses=%0d en=%b want %0d %b", pcnt[2], ch_en, epul[2], men);
      end
   endtask

   task automatic test_errors();
      txq.delete(); expq.delete();
      send_cmd("M", "7", "1");
      send_cmd("M", "1", "x");
      nvec++;
      if (q2s(txq) != q2s(expq)) begin
         nfail++; $display("FAIL err_reply got %s want %s", q2s(txq), q2s(expq));
      end
      nvec++;
      if (errs !== eerr || ch_en !== men) begin
         nfail++; $display("FAIL err_count got err=%0d en=%b want %0d %b", errs, ch_en, eerr, men);
      end
   endtask

   task automatic test_timeout();
      int e0;
      txq.delete(); expq.delete();
      e0 = errs;
      send_byte("M", 2);
      send_byte("0", 0);
      repeat (95) @(negedge clk);
      nvec++;
      if (errs !== e0) begin
         nfail++; $display("FAIL tmo_early got err=%0d want %0d", errs, e0);
      end
      repeat (10) @(negedge clk);
      eerr++; ph = 0;
      nvec++;
      if (errs !== eerr || txq.size() != 0) begin
         nfail++;
         $display("FAIL tmo_fire got err=%0d tx=%0d want %0d 0", errs, txq.size(), eerr);
      end
      send_cmd("M", "0", "1");
      nvec++;
      if (q2s(txq) != q2s(expq) || ch_en !== men) begin
         nfail++; $display("FAIL tmo_after got %s en=%b want %s %b", q2s(txq), ch_en, q2s(expq), men);
      end
   endtask

   task automatic test_back_to_back();
      txq.delete(); expq.delete();
      send_byte("M", 0); send_byte("M", 1); send_byte("3", 0); send_byte("1", 0);
      send_byte("M", 0); send_byte("0", 0); send_byte("0", 0);
      drain();
      nvec++;
      if (q2s(txq) != q2s(expq) || ch_en !== men || ch_en[3] !== 1'b1) begin
         nfail++; $display("FAIL b2b got %s en=%b want %s %b", q2s(txq), ch_en, q2s(expq), men);
      end
   endtask

   task automatic test_random();
      logic [7:0] chs [9] = '{"0", "1", "2", "3", "5", "9", "M", "x", "?"};
      logic [7:0] vls [7] = '{"0", "1", "1", "0", "M", "z", "?"};
      txq.delete(); expq.delete();
      for (int k = 0; k < 25; k++)
         send_cmd("M", chs[$urandom_range(8, 0)], vls[$urandom_range(6, 0)]);
      nvec++;
      if (q2s(txq) != q2s(expq)) begin
         nfail++; $display("FAIL rnd_reply got %s want %s", q2s(txq), q2s(expq));
      end
      nvec++;
      if (ch_en !== men || errs !== eerr || viol !== 0) begin
         nfail++;
         $display("FAIL rnd_state got en=%b err=%0d viol=%0d want %b %0d 0", ch_en, errs, viol, men, eerr);
      end
      for (int i = 0; i < CH_NUM; i++) begin
         nvec++;
         if (pcnt[i] !== epul[i]) begin
            nfail++; $display("FAIL rnd_pulse%0d got %0d want %0d", i, pcnt[i], epul[i]);
         end
      end
   endtask

   task automatic test_query_rst();
      logic [7:0] first;
      int         n = 0;
      send_cmd("M", "0", "0"); send_cmd("M", "2", "0");
      send_cmd("M", "1", "1"); send_cmd("M", "3", "1");
      txq.delete(); expq.delete();
      send_cmd("M", "?", "?");
      nvec++;
      if (q2s(txq) != q2s(expq)) begin
         nfail++; $display("FAIL qry_reply got %s want %s", q2s(txq), q2s(expq));
      end
      txq.delete(); expq.delete();
      send_byte("M", 0); send_byte("?", 0); send_byte("?", 0);
      first = expq[0];
      while (txq.size() < 1 && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      nvec++;
      if ({ch_en, ch_pulse, tx_start, tx_data, cmd_err} !== '0) begin
         nfail++;
         $display("FAIL rst_mid got en=%b pul=%b st=%b d=%h err=%b want all 0",
                  ch_en, ch_pulse, tx_start, tx_data, cmd_err);
      end
      rst = 1'b0; men = '0; ph = 0;
      repeat (40) @(negedge clk);
      nvec++;
      if (txq.size() != 1 || txq[0] !== first) begin
         nfail++; $display("FAIL rst_drop got %s want %02h only", q2s(txq), first);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_repeat();
      test_errors();
      test_timeout();
      test_back_to_back();
      test_random();
      test_query_rst();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
